// File: rtl/alu_exec_ctrl_pkg.sv
// alu_exec_ctrl_pkg: opcode/opext constants, FSM states, PSR bit
// positions and the instruction retire classification.
package alu_exec_ctrl_pkg;

  localparam logic [3:0] OP_RR    = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ADDUI = 4'b0110;
  localparam logic [3:0] OP_ADDCI = 4'b0111;
  localparam logic [3:0] OP_IMM8  = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_R2    = 4'b1010;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_IMM14 = 4'b1110;

  localparam logic [3:0] EXT_AND    = 4'b0001;
  localparam logic [3:0] EXT_OR     = 4'b0010;
  localparam logic [3:0] EXT_XOR    = 4'b0011;
  localparam logic [3:0] EXT_ADD    = 4'b0101;
  localparam logic [3:0] EXT_ADDU   = 4'b0110;
  localparam logic [3:0] EXT_ADDC   = 4'b0111;
  localparam logic [3:0] EXT_SUB    = 4'b1001;
  localparam logic [3:0] EXT_CMP    = 4'b1011;
  localparam logic [3:0] EXT_MOV    = 4'b1101;
  localparam logic [3:0] EXT_CMPU   = 4'b0010;
  localparam logic [3:0] EXT_ADDCU  = 4'b0101;
  localparam logic [3:0] EXT_ADDCUI = 4'b0110;

  localparam int PSR_C = 4;
  localparam int PSR_F = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LOAD, S_EXEC, S_EXEC2, S_WB
  } state_t;

  typedef enum logic [1:0] {K_NONE, K_WB, K_CMP} kind_t;

  function automatic kind_t f_kind(input logic [15:0] i);
    kind_t k;
    k = K_NONE;
    case (i[15:12])
      OP_RR:
        case (i[7:4])
          EXT_CMP: k = K_CMP;
          EXT_AND, EXT_OR, EXT_XOR, EXT_ADD, EXT_ADDU,
          EXT_ADDC, EXT_SUB, EXT_MOV: k = K_WB;
          default: k = K_NONE;
        endcase
      OP_R2:
        case (i[7:4])
          EXT_CMPU: k = K_CMP;
          EXT_ADDCU, EXT_ADDCUI: k = K_WB;
          default: k = K_NONE;
        endcase
      OP_CMPI: k = K_CMP;
      OP_ADDI, OP_ADDUI, OP_ADDCI, OP_IMM8,
      OP_SUBI, OP_MOVI, OP_IMM14: k = K_WB;
      default: k = K_NONE;
    endcase
    return k;
  endfunction

  function automatic logic f_addc(input logic [15:0] i);
    return (i[15:12] == OP_RR && i[7:4] == EXT_ADDC) ||
           (i[15:12] == OP_ADDCI) ||
           (i[15:12] == OP_R2 &&
            (i[7:4] == EXT_ADDCU || i[7:4] == EXT_ADDCUI));
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_operand_sel.sv
// alu_exec_ctrl_operand_sel: immediate extension and the
// op_a/op_b source mux used when operands are loaded.
module alu_exec_ctrl_operand_sel
  import alu_exec_ctrl_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        i_op,
  input  logic [7:0]        i_imm8,
  input  logic [DATA_W-1:0] i_ra,
  input  logic [DATA_W-1:0] i_rb,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b
);

  logic [DATA_W-1:0] w_sx;
  logic [DATA_W-1:0] w_zx;
  logic [DATA_W-1:0] w_imm;
  logic              w_imm_form;

  assign w_sx = {{(DATA_W-8){i_imm8[7]}}, i_imm8};
  assign w_zx = {{(DATA_W-8){1'b0}}, i_imm8};

  always_comb begin
    w_imm_form = 1'b0;
    w_imm      = w_sx;
    case (i_op)
      OP_ADDI, OP_ADDCI, OP_SUBI, OP_CMPI: w_imm_form = 1'b1;
      OP_ADDUI, OP_IMM8, OP_IMM14: begin
        w_imm_form = 1'b1;
        w_imm      = w_zx;
      end
      default: w_imm_form = 1'b0;
    endcase
  end

  assign o_b = w_imm_form ? w_imm : i_rb;

  always_comb begin
    unique case (1'b1)
      i_op == OP_MOVI:                         o_a = w_sx;
      i_op == OP_RR && i_imm8[7:4] == EXT_MOV: o_a = i_rb;
      default:                                 o_a = i_ra;
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: issue -> regfile read -> ALU -> writeback sequencer,
// owns the PSR and resolves ADDC carry-in with a second ADDU pass.
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [REG_AW-1:0] rf_ra_addr,
  output logic [REG_AW-1:0] rf_rb_addr,
  input  logic [DATA_W-1:0] rf_ra_data,
  input  logic [DATA_W-1:0] rf_rb_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_opcode,
  output logic [3:0]        alu_opext,
  input  logic [DATA_W-1:0] alu_s,
  input  logic [4:0]        alu_flags,
  output logic [4:0]        psr,
  output logic              done
);

  state_t            r_state;
  logic [15:0]       r_instr;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [DATA_W-1:0] r_res;
  logic [3:0]        r_alu_op;
  logic [3:0]        r_alu_ext;
  logic [4:0]        r_flg;
  logic [4:0]        r_psr;
  logic              r_a_msb;
  logic              r_b_msb;
  logic              r_c2;
  logic              r_ready;

  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;
  kind_t             w_kind;
  logic              w_addc;
  logic              w_addc_c;
  logic              w_ov;
  logic [4:0]        w_addc_psr;

  alu_exec_ctrl_operand_sel #(.DATA_W(DATA_W)) u_sel (
    .i_op   (r_instr[15:12]),
    .i_imm8 (r_instr[7:0]),
    .i_ra   (rf_ra_data),
    .i_rb   (rf_rb_data),
    .o_a    (w_sel_a),
    .o_b    (w_sel_b)
  );

  assign w_kind = f_kind(r_instr);
  assign w_addc = f_addc(r_instr);

  // ADDC flags: carry from either pass, overflow over the final sum
  always_comb begin
    w_addc_c = r_flg[PSR_C] | r_c2;
    w_ov = (~r_a_msb & ~r_b_msb & r_res[DATA_W-1]) |
           (r_a_msb & r_b_msb & ~r_res[DATA_W-1]);
    w_addc_psr = '0;
    w_addc_psr[PSR_C] = w_addc_c;
    unique case (1'b1)
      r_instr[15:12] == OP_R2 && r_instr[7:4] == EXT_ADDCU:
        w_addc_psr[PSR_F] = 1'b0;
      r_instr[15:12] == OP_R2 && r_instr[7:4] == EXT_ADDCUI:
        w_addc_psr[PSR_F] = w_addc_c;
      default:
        w_addc_psr[PSR_F] = w_ov;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_instr   <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_res     <= '0;
      r_alu_op  <= '0;
      r_alu_ext <= '0;
      r_flg     <= '0;
      r_psr     <= '0;
      r_a_msb   <= 1'b0;
      r_b_msb   <= 1'b0;
      r_c2      <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (instr_valid && r_ready) begin
            r_instr <= instr;
            r_ready <= 1'b0;
            r_state <= S_READ;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_READ: r_state <= S_LOAD;
        S_LOAD: begin
          r_a_msb   <= w_sel_a[DATA_W-1];
          r_b_msb   <= w_sel_b[DATA_W-1];
          r_alu_a   <= w_sel_a;
          r_alu_b   <= w_sel_b;
          r_alu_op  <= r_instr[15:12];
          r_alu_ext <= r_instr[7:4];
          r_state   <= S_EXEC;
        end
        S_EXEC: begin
          r_res <= alu_s;
          r_flg <= alu_flags;
          r_c2  <= 1'b0;
          if (w_addc) begin
            r_alu_a   <= alu_s;
            r_alu_b   <= {{(DATA_W-1){1'b0}}, r_psr[PSR_C]};
            r_alu_op  <= OP_RR;
            r_alu_ext <= EXT_ADDU;
            r_state   <= S_EXEC2;
          end else begin
            r_state <= S_WB;
          end
        end
        S_EXEC2: begin
          r_res   <= alu_s;
          r_c2    <= alu_flags[PSR_C];
          r_state <= S_WB;
        end
        S_WB: begin
          if (w_addc) r_psr <= w_addc_psr;
          else if (w_kind != K_NONE) r_psr <= r_flg;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = r_ready;
  assign rf_ra_addr  = r_instr[11:8];
  assign rf_rb_addr  = r_instr[3:0];
  assign rf_waddr    = r_instr[11:8];
  assign rf_wdata    = r_res;
  assign done        = (r_state == S_WB);
  assign rf_we       = done && (w_kind == K_WB);
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_opcode  = r_alu_op;
  assign alu_opext   = r_alu_ext;
  assign psr         = r_psr;

endmodule
